// File: rtl/led_painel_pkg.sv
// Shared constants and types for the front-panel LED controller.
package led_painel_pkg;

    localparam logic [1:0] ADDR_SW_PATTERN = 2'd0;
    localparam logic [1:0] ADDR_HW_SELECT  = 2'd1;
    localparam logic [1:0] ADDR_BLINK_MASK = 2'd2;
    localparam logic [1:0] ADDR_CTRL       = 2'd3;

    localparam int CTRL_LAMP_START_BIT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK   = 2'd1,
        ALL_ON = 2'd2
    } lamp_state_e;

endpackage

// File: rtl/led_painel_controller_if.sv
// Avalon-MM slave register port of the LED panel controller.
interface led_painel_controller_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/led_tick_prescaler.sv
// Free-running timebase: one-cycle tick every TICK_DIV clocks.
module led_tick_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // NOTE: state is updated with <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_painel_controller.sv
// LED panel sequencer: software/hardware source muxing, event stretching,
// blinking and a self-running lamp test, behind an Avalon-MM register port.
module led_painel_controller
    import led_painel_pkg::*;
#(
    parameter int                   LED_WIDTH       = 21,
    parameter int                   TICK_DIV        = 50000,
    parameter int                   STRETCH_TICKS   = 100,
    parameter int                   LAMP_STEP_TICKS = 250,
    parameter logic [LED_WIDTH-1:0] SW_RESET_VAL    = LED_WIDTH'('h10000),
    parameter logic [15:0]          BLINK_RESET_VAL = 16'd500
) (
    input  logic                    clk,
    input  logic                    reset_n,
    led_painel_controller_if.slave  bus,
    input  logic [LED_WIDTH-1:0]    hw_event,
    output logic [LED_WIDTH-1:0]    out_port,
    output logic                    lamp_test_busy
);

    localparam int SC_W = $clog2(STRETCH_TICKS + 1);
    localparam logic [SC_W-1:0] SC_LOAD = SC_W'(STRETCH_TICKS);
    localparam int STEP_W = (LAMP_STEP_TICKS > 1) ? $clog2(LAMP_STEP_TICKS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LAMP_STEP_TICKS - 1);
    localparam int IDX_W = $clog2(LED_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LED_WIDTH - 1);
    localparam logic [LED_WIDTH-1:0] LED_ONE = LED_WIDTH'(1);

    logic                 tick;
    logic                 wr_en, wr_sw, wr_hw, wr_mask, wr_ctrl, lamp_start;
    logic [LED_WIDTH-1:0] sw_pattern, hw_select, blink_mask;
    logic [15:0]          blink_half;
    logic [31:0]          rdata;
    logic                 unused_wdata;

    logic [SC_W-1:0]      stretch_cnt [LED_WIDTH];
    logic [LED_WIDTH-1:0] hw_on;

    logic [15:0]          blink_cnt;
    logic                 blink_phase;

    lamp_state_e          state, state_next;
    logic [IDX_W-1:0]     idx;
    logic [STEP_W-1:0]    step_cnt;
    logic                 step_done;
    logic [LED_WIDTH-1:0] normal_led, next_led;

    led_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign wr_en      = bus.chipselect & ~bus.write_n;
    assign wr_sw      = wr_en && (bus.address == ADDR_SW_PATTERN);
    assign wr_hw      = wr_en && (bus.address == ADDR_HW_SELECT);
    assign wr_mask    = wr_en && (bus.address == ADDR_BLINK_MASK);
    assign wr_ctrl    = wr_en && (bus.address == ADDR_CTRL);
    assign lamp_start = wr_ctrl && bus.writedata[CTRL_LAMP_START_BIT];
    assign unused_wdata = ^bus.writedata[31:LED_WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_pattern <= SW_RESET_VAL;
            hw_select  <= '0;
            blink_mask <= '0;
            blink_half <= BLINK_RESET_VAL;
        end else begin
            if (wr_sw)   sw_pattern <= bus.writedata[LED_WIDTH-1:0];
            if (wr_hw)   hw_select  <= bus.writedata[LED_WIDTH-1:0];
            if (wr_mask) blink_mask <= bus.writedata[LED_WIDTH-1:0];
            if (wr_ctrl) blink_half <= bus.writedata[15:0];
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_SW_PATTERN: rdata = 32'(sw_pattern);
            ADDR_HW_SELECT:  rdata = 32'(hw_select);
            ADDR_BLINK_MASK: rdata = 32'(blink_mask);
            default:         rdata = {15'd0, lamp_test_busy, blink_half};
        endcase
    end

    assign bus.readdata = rdata;

    // NOTE: the stretch counters are discrete flops, not a RAM, so resetting them all is cheap and required.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LED_WIDTH; i++) stretch_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < LED_WIDTH; i++) begin
                if (hw_event[i]) begin
                    stretch_cnt[i] <= SC_LOAD;
                end else if (tick && (stretch_cnt[i] != '0)) begin
                    stretch_cnt[i] <= stretch_cnt[i] - SC_W'(1);
                end
            end
        end
    end

    always_comb begin
        hw_on = '0;
        for (int i = 0; i < LED_WIDTH; i++) hw_on[i] = (stretch_cnt[i] != '0);
    end

    // A CTRL write realigns the blink so a new half-period starts from the lit phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (wr_ctrl || (blink_half == '0)) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (tick) begin
            if (blink_cnt == blink_half - 16'd1) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    assign step_done = tick && (step_cnt == STEP_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            lamp_test_busy <= 1'b0;
        end else begin
            state          <= state_next;
            lamp_test_busy <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (lamp_start) state_next = WALK;
            WALK:    if (step_done && (idx == IDX_LAST)) state_next = ALL_ON;
            ALL_ON:  if (step_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Held at zero while idle, so both counters start from zero on entry to WALK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            step_cnt <= '0;
        end else if (state == IDLE) begin
            idx      <= '0;
            step_cnt <= '0;
        end else if (step_done) begin
            step_cnt <= '0;
            if (state == WALK) idx <= idx + IDX_W'(1);
        end else if (tick) begin
            step_cnt <= step_cnt + STEP_W'(1);
        end
    end

    always_comb begin
        normal_led = ((hw_select & hw_on) | (~hw_select & sw_pattern))
                     & (~blink_mask | {LED_WIDTH{blink_phase}});
        next_led = normal_led;
        case (state)
            WALK:    next_led = LED_ONE << idx;
            ALL_ON:  next_led = '1;
            default: next_led = normal_led;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= SW_RESET_VAL;
        end else begin
            out_port <= next_led;
        end
    end

endmodule

// File: tb/tb_led_painel_controller.sv
// Scoreboard bench: stimulus queues expected out_port changes and register samples, a negedge monitor checks them.
module tb_led_painel_controller;

    localparam int LED_WIDTH = 21;

    typedef struct packed {
        logic [LED_WIDTH-1:0] value;
        int                   lo;
        int                   hi;
    } chg_t;

    typedef struct packed {
        logic [31:0]          data;
        logic                 busy;
        logic [LED_WIDTH-1:0] out;
        logic                 chk_out;
    } smp_t;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [LED_WIDTH-1:0] hw_event;
    logic [LED_WIDTH-1:0] out_port;
    logic                 lamp_test_busy;

    led_painel_controller_if bus ();

    led_painel_controller #(
        .LED_WIDTH       (LED_WIDTH),
        .TICK_DIV        (4),
        .STRETCH_TICKS   (3),
        .LAMP_STEP_TICKS (2),
        .SW_RESET_VAL    (21'h10000),
        .BLINK_RESET_VAL (16'd500)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .hw_event       (hw_event),
        .out_port       (out_port),
        .lamp_test_busy (lamp_test_busy)
    );

    always #5 clk = ~clk;

    chg_t chg_q[$];
    smp_t smp_q[$];
    logic strobe = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_chg   = 0;
    int   n_smp   = 0;
    int   held    = 0;
    logic [LED_WIDTH-1:0] last_out;
    chg_t c;
    smp_t s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d clocks, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: register samples on strobe, and every out_port change against the change queue.
    always @(negedge clk) begin
        if (strobe) begin
            if (smp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL smp%0d: got a sample strobe, expected a queued sample", n_smp);
            end else begin
                s = smp_q.pop_front();
                check($sformatf("smp%0d_readdata", n_smp), bus.readdata, s.data);
                check($sformatf("smp%0d_busy", n_smp), 32'(lamp_test_busy), 32'(s.busy));
                if (s.chk_out) check($sformatf("smp%0d_out_port", n_smp), 32'(out_port), 32'(s.out));
            end
            n_smp++;
        end
        if (!reset_n) begin
            last_out = out_port;
            held     = 0;
        end else if (out_port !== last_out) begin
            if (chg_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_change: got 0x%0h, expected no change from 0x%0h", out_port, last_out);
            end else begin
                c = chg_q.pop_front();
                check($sformatf("chg%0d_value", n_chg), 32'(out_port), 32'(c.value));
                if (c.lo != 0) check_range($sformatf("chg%0d_hold", n_chg), held, c.lo, c.hi);
            end
            n_chg++;
            last_out = out_port;
            held     = 1;
        end else begin
            held++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        cyc();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic sample(input logic [1:0] addr, input logic [31:0] data, input logic busy,
                          input logic [LED_WIDTH-1:0] out, input logic chk_out);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        smp_q.push_back('{data: data, busy: busy, out: out, chk_out: chk_out});
        strobe = 1'b1;
        cyc();
        strobe = 1'b0;
        bus.chipselect = 1'b0;
    endtask

    task automatic expect_chg(input logic [LED_WIDTH-1:0] value, input int lo, input int hi);
        chg_q.push_back('{value: value, lo: lo, hi: hi});
    endtask

    task automatic pulse(input int i);
        hw_event = LED_WIDTH'(1) << i;
        cyc();
        hw_event = '0;
    endtask

    task automatic drain(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (chg_q.size() == 0) break;
            cyc();
        end
        check(name, chg_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b1;
        hw_event       = '0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        sample(2'd3, 32'd500, 1'b0, 21'h10000, 1'b1);

        // Software pattern, one-cycle latency
        expect_chg(21'h00055, 0, 0);
        wr(2'd0, 32'h55);
        sample(2'd0, 32'h55, 1'b0, 21'h10000, 1'b1);
        sample(2'd0, 32'h55, 1'b0, 21'h00055, 1'b1);
        drain(10, "sw_pattern_drain");

        // Hardware event stretch and retrigger
        expect_chg(21'h00054, 0, 0);
        wr(2'd1, 32'h1);
        sample(2'd1, 32'h1, 1'b0, '0, 1'b0);
        drain(10, "hw_select_drain");
        expect_chg(21'h00055, 0, 0);
        expect_chg(21'h00054, 9, 12);
        pulse(0);
        drain(40, "stretch_drain");
        expect_chg(21'h00055, 0, 0);
        expect_chg(21'h00054, 15, 18);
        pulse(0);
        repeat (5) cyc();
        pulse(0);
        drain(40, "retrigger_drain");

        // Blink with half-period 2, then steady on
        expect_chg(21'h00055, 0, 0);
        wr(2'd1, 32'h0);
        expect_chg(21'h00001, 0, 0);
        wr(2'd0, 32'h1);
        wr(2'd3, 32'h2);
        wr(2'd2, 32'h1);
        expect_chg(21'h00000, 0, 0);
        expect_chg(21'h00001, 8, 8);
        expect_chg(21'h00000, 8, 8);
        drain(100, "blink_drain");
        expect_chg(21'h00001, 0, 0);
        wr(2'd3, 32'h0);
        drain(10, "blink_off_drain");
        repeat (30) cyc();
        sample(2'd3, 32'h0, 1'b0, 21'h00001, 1'b1);

        // Lamp test walk, all-on, return; second start ignored
        wr(2'd2, 32'h0);
        expect_chg(21'h0AAAA, 0, 0);
        wr(2'd0, 32'h0AAAA);
        drain(10, "pre_lamp_drain");
        expect_chg(21'h00001, 0, 0);
        expect_chg(21'h00002, 5, 8);
        for (int k = 2; k < LED_WIDTH; k++) expect_chg(LED_WIDTH'(1) << k, 8, 8);
        expect_chg(21'h1FFFFF, 8, 8);
        expect_chg(21'h0AAAA, 8, 8);
        wr(2'd3, 32'h10000);
        sample(2'd3, 32'h10000, 1'b1, '0, 1'b0);
        repeat (30) cyc();
        wr(2'd3, 32'h10000);
        sample(2'd3, 32'h10000, 1'b1, '0, 1'b0);
        drain(300, "lamp_drain");
        sample(2'd3, 32'h0, 1'b0, 21'h0AAAA, 1'b1);

        // Reset mid-walk
        expect_chg(21'h00001, 0, 0);
        expect_chg(21'h00002, 5, 8);
        expect_chg(21'h00004, 8, 8);
        wr(2'd3, 32'h10000);
        drain(60, "reset_walk_drain");
        cyc();
        reset_n = 1'b0;
        sample(2'd3, 32'd500, 1'b0, 21'h10000, 1'b1);
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (40) cyc();
        sample(2'd3, 32'd500, 1'b0, 21'h10000, 1'b1);
        sample(2'd0, 32'h10000, 1'b0, 21'h10000, 1'b1);
        sample(2'd1, 32'h0, 1'b0, 21'h10000, 1'b1);

        check("final_chg_queue", chg_q.size(), 0);
        check("final_smp_queue", smp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
